// File: rtl/signed_shift_sat_pipe.sv
// Multi-channel two-stage signed scaler: arithmetic right shift with selectable
// rounding, then saturation to OUT_W bits, plus per-channel flags, sticky status and an event counter.
module signed_shift_sat_pipe #(
    parameter int IN_W    = 32,
    parameter int OUT_W   = 16,
    parameter int NUM_CH  = 2,
    parameter int SHIFT_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [SHIFT_W-1:0]      shift,
    input  logic [1:0]              round_mode,
    input  logic                    sym_sat,
    input  logic                    in_valid,
    input  logic [NUM_CH*IN_W-1:0]  in_data,
    output logic                    out_valid,
    output logic [NUM_CH*OUT_W-1:0] out_data,
    output logic [NUM_CH-1:0]       sat_flag,
    output logic [NUM_CH-1:0]       sat_sticky,
    input  logic                    sticky_clear,
    output logic [CNT_W-1:0]        sat_count
);

    localparam int XW = IN_W + 1;

    typedef enum logic [1:0] {
        RND_TRUNC   = 2'd0,
        RND_HALF_UP = 2'd1,
        RND_CONV    = 2'd2,
        RND_RSVD    = 2'd3
    } round_e;

    localparam logic signed [XW-1:0] C_MAX      = {{(XW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [XW-1:0] C_MIN_FULL = {{(XW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic signed [XW-1:0] C_MIN_SYM  = C_MIN_FULL + XW'(1);

    logic [31:0]              w_shift_u;
    logic [31:0]              w_s;
    logic signed [XW-1:0]     w_x;
    logic signed [XW-1:0]     w_trunc;
    logic signed [XW-1:0]     w_half;
    logic [XW-1:0]            w_half_lsb;
    logic [XW-1:0]            w_mask;
    logic                     w_tie;
    logic signed [XW-1:0]     w_rnd [NUM_CH];

    logic                     r_s1_valid;
    logic                     r_s1_sym;
    logic signed [XW-1:0]     r_s1_val [NUM_CH];

    logic signed [XW-1:0]     w_min;
    logic [NUM_CH*OUT_W-1:0]  w_sat_data;
    logic [NUM_CH-1:0]        w_sat_flag;

    logic                     r_out_valid;
    logic [NUM_CH*OUT_W-1:0]  r_out_data;
    logic [NUM_CH-1:0]        r_sat_flag;
    logic [NUM_CH-1:0]        r_sat_sticky;
    logic [CNT_W-1:0]         r_sat_count;
    logic                     w_event;

    // Shifts beyond IN_W-1 would only replicate the sign bit, so clamp there.
    assign w_shift_u = 32'(shift);
    assign w_s       = (w_shift_u > 32'(IN_W - 1)) ? 32'(IN_W - 1) : w_shift_u;

    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        w_half_lsb = (w_s == 32'd0) ? '0 : (XW'(1) << (w_s - 32'd1));
        w_mask     = (XW'(1) << w_s) - XW'(1);
        w_x        = '0;
        w_trunc    = '0;
        w_half     = '0;
        w_tie      = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_x     = {in_data[k*IN_W+IN_W-1], in_data[k*IN_W +: IN_W]};
            w_trunc = w_x >>> w_s;
            w_half  = (w_x + $signed(w_half_lsb)) >>> w_s;
            w_tie   = ((w_x & w_mask) == w_half_lsb) && !w_trunc[0];
            case (round_e'(round_mode))
                RND_HALF_UP: w_rnd[k] = w_half;
                RND_CONV:    w_rnd[k] = w_tie ? w_trunc : w_half;
                default:     w_rnd[k] = w_trunc;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: stage-1 data carries no reset; it is never observed unless its valid bit is set.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= in_valid;
        end
        if (in_valid) begin
            r_s1_sym <= sym_sat;
            for (int k = 0; k < NUM_CH; k++) begin
                r_s1_val[k] <= w_rnd[k];
            end
        end
    end

    always_comb begin
        w_min      = r_s1_sym ? C_MIN_SYM : C_MIN_FULL;
        w_sat_data = '0;
        w_sat_flag = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (r_s1_val[k] > C_MAX) begin
                w_sat_data[k*OUT_W +: OUT_W] = C_MAX[OUT_W-1:0];
                w_sat_flag[k]                = 1'b1;
            end else if (r_s1_val[k] < w_min) begin
                w_sat_data[k*OUT_W +: OUT_W] = w_min[OUT_W-1:0];
                w_sat_flag[k]                = 1'b1;
            end else begin
                w_sat_data[k*OUT_W +: OUT_W] = r_s1_val[k][OUT_W-1:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_sat_flag  <= '0;
        end else begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= w_sat_data;
                r_sat_flag <= w_sat_flag;
            end
        end
    end

    // Status follows the presented output; a set in the same cycle as a clear takes priority.
    assign w_event = r_out_valid && (|r_sat_flag);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sat_sticky <= '0;
            r_sat_count  <= '0;
        end else begin
            r_sat_sticky <= (sticky_clear ? '0 : r_sat_sticky) | (r_out_valid ? r_sat_flag : '0);
            if (sticky_clear) begin
                r_sat_count <= CNT_W'(w_event);
            end else if (w_event && (r_sat_count != {CNT_W{1'b1}})) begin
                r_sat_count <= r_sat_count + CNT_W'(1);
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign sat_flag   = r_sat_flag;
    assign sat_sticky = r_sat_sticky;
    assign sat_count  = r_sat_count;

endmodule

// File: tb/tb_signed_shift_sat_pipe.sv
// Scoreboard bench for signed_shift_sat_pipe: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them whenever out_valid is presented.
module tb_signed_shift_sat_pipe;

    localparam int IN_W    = 32;
    localparam int OUT_W   = 16;
    localparam int NUM_CH  = 2;
    localparam int SHIFT_W = 6;
    localparam int CNT_W   = 3;

    logic                    clock = 1'b0;
    logic                    reset;
    logic [SHIFT_W-1:0]      shift;
    logic [1:0]              round_mode;
    logic                    sym_sat;
    logic                    in_valid;
    logic [NUM_CH*IN_W-1:0]  in_data;
    logic                    out_valid;
    logic [NUM_CH*OUT_W-1:0] out_data;
    logic [NUM_CH-1:0]       sat_flag;
    logic [NUM_CH-1:0]       sat_sticky;
    logic                    sticky_clear;
    logic [CNT_W-1:0]        sat_count;

    typedef struct {
        logic [OUT_W-1:0] d0;
        logic [OUT_W-1:0] d1;
        logic [1:0]       flag;
        int               due;
    } exp_t;

    exp_t        sb_q[$];
    int          cyc = 0;
    int          n_total = 0;
    int          n_pass = 0;
    logic [31:0] last_exp = '0;

    signed_shift_sat_pipe #(
        .IN_W(IN_W), .OUT_W(OUT_W), .NUM_CH(NUM_CH), .SHIFT_W(SHIFT_W), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset), .shift(shift), .round_mode(round_mode),
        .sym_sat(sym_sat), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data), .sat_flag(sat_flag),
        .sat_sticky(sat_sticky), .sticky_clear(sticky_clear), .sat_count(sat_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic drive(input logic v, input logic [31:0] d0, input logic [31:0] d1,
                         input int sh, input int rm, input logic sym,
                         input logic clr, input logic rst);
        @(posedge clock);
        #1;
        in_valid     = v;
        in_data      = {d1, d0};
        shift        = SHIFT_W'(sh);
        round_mode   = 2'(rm);
        sym_sat      = sym;
        sticky_clear = clr;
        reset        = rst;
    endtask

    task automatic send(input logic [31:0] d0, input logic [31:0] d1, input int sh,
                        input int rm, input logic sym, input int e0, input int e1,
                        input logic [1:0] ef);
        exp_t e;
        drive(1'b1, d0, d1, sh, rm, sym, 1'b0, 1'b0);
        e.d0   = OUT_W'(e0);
        e.d1   = OUT_W'(e1);
        e.flag = ef;
        e.due  = cyc + 2;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: pops on every presented output, checks latency, and checks hold when idle.
    always @(negedge clock) begin
        if (!reset) begin
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_out", 64'(out_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("latency", 64'(cyc), 64'(e.due));
                    check("ch0_data", 64'(out_data[0 +: OUT_W]), 64'(e.d0));
                    check("ch1_data", 64'(out_data[OUT_W +: OUT_W]), 64'(e.d1));
                    check("sat_flag", 64'(sat_flag), 64'(e.flag));
                    last_exp = {e.d1, e.d0};
                end
            end else begin
                check("hold_data", 64'(out_data), 64'(last_exp));
                if (sb_q.size() != 0) check("missing_out", 64'(sb_q[0].due <= cyc), 64'd0);
            end
        end
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; shift = '0;
        round_mode = '0; sym_sat = 1'b0; sticky_clear = 1'b0;
        repeat (3) @(posedge clock);
        idle(1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_sat_flag", 64'(sat_flag), 64'd0);
        check("rst_sticky", 64'(sat_sticky), 64'd0);
        check("rst_count", 64'(sat_count), 64'd0);

        // Rounding at shift=4; ch1 = -8 probes the negative half-way case.
        send(-17, -8, 4, 0, 1'b0, -2, -1, 2'b00);
        send( 24, -8, 4, 0, 1'b0,  1, -1, 2'b00);
        send( 40, -8, 4, 0, 1'b0,  2, -1, 2'b00);
        send(  8, -8, 4, 0, 1'b0,  0, -1, 2'b00);
        send(-17, -8, 4, 1, 1'b0, -1,  0, 2'b00);
        send( 24, -8, 4, 1, 1'b0,  2,  0, 2'b00);
        send( 40, -8, 4, 1, 1'b0,  3,  0, 2'b00);
        send(  8, -8, 4, 1, 1'b0,  1,  0, 2'b00);
        send(-17, -8, 4, 2, 1'b0, -1,  0, 2'b00);
        send( 24, -8, 4, 2, 1'b0,  2,  0, 2'b00);
        send( 40, -8, 4, 2, 1'b0,  2,  0, 2'b00);
        send(  8, -8, 4, 2, 1'b0,  0,  0, 2'b00);
        send(-17, -8, 4, 3, 1'b0, -2, -1, 2'b00);
        send(  7, -7, 0, 1, 1'b0,  7, -7, 2'b00);

        // Saturation at shift=0, including exact-limit values on ch1.
        send(32'h7FFF_FFFF,  32767, 0, 0, 1'b0,  32767,  32767, 2'b01);
        send(32'h8000_0000, -32768, 0, 0, 1'b0, -32768, -32768, 2'b01);
        send(32'h8000_0000, -32768, 0, 0, 1'b1, -32767, -32767, 2'b11);
        send(1000,           -1000, 0, 0, 1'b0,   1000,  -1000, 2'b00);
        send(1000,           32768, 0, 0, 1'b0,   1000,  32767, 2'b10);

        // Rounding that crosses the output range.
        send(32'h7FFF_FFFF, 32'h8000_0000, 16, 1, 1'b0, 32767, -32768, 2'b01);
        send(32'h7FFF_FFFF, 32'h8000_0000, 16, 0, 1'b0, 32767, -32768, 2'b00);

        // Shift amounts above IN_W-1 clamp to IN_W-1.
        send(32'h8000_0000, 32'h7FFF_FFFF, 31, 0, 1'b0, -1, 0, 2'b00);
        send(32'h8000_0000, 32'h7FFF_FFFF, 40, 0, 1'b0, -1, 0, 2'b00);
        send(32'h8000_0000, 32'h7FFF_FFFF, 31, 1, 1'b0, -1, 1, 2'b00);
        send(32'h8000_0000, 32'h7FFF_FFFF, 40, 1, 1'b0, -1, 1, 2'b00);

        // Gapped valid pattern 1101_1110; monitor checks delay and hold.
        begin
            logic [7:0] pat;
            pat = 8'b1101_1110;
            for (int i = 7; i >= 0; i--) begin
                if (pat[i]) send(i * 16, -(i * 32), 4, 0, 1'b0, i, -(i * 2), 2'b00);
                else        idle(1);
            end
        end

        idle(3);
        drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
        idle(3);
        check("clear_count", 64'(sat_count), 64'd0);
        check("clear_sticky", 64'(sat_sticky), 64'd0);

        // Ten ch1-only saturations into a 3-bit counter.
        for (int i = 0; i < 10; i++) send(5, 32'h7FFF_FFFF, 0, 0, 1'b0, 5, 32767, 2'b10);
        idle(4);
        check("cnt_saturates", 64'(sat_count), 64'd7);
        check("sticky_ch1", 64'(sat_sticky), 64'b10);

        // Clear lands in the same cycle the saturating output is presented.
        send(5, 32'h7FFF_FFFF, 0, 0, 1'b0, 5, 32767, 2'b10);
        idle(1);
        drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
        idle(3);
        check("coinc_count", 64'(sat_count), 64'd1);
        check("coinc_sticky", 64'(sat_sticky), 64'b10);

        drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
        idle(3);
        check("clear2_count", 64'(sat_count), 64'd0);
        check("clear2_sticky", 64'(sat_sticky), 64'd0);

        // Mid-stream reset with two saturating samples in flight; neither may emerge.
        send(32'h7FFF_FFFF, 32'h8000_0000, 0, 0, 1'b0, 32767, -32768, 2'b11);
        idle(4);
        check("pre_rst_count", 64'(sat_count), 64'd1);
        drive(1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h8000_0000, 32'h8000_0000, 0, 0, 1'b0, 1'b0, 1'b1);
        last_exp = '0;
        send(48, -48, 4, 0, 1'b0, 3, -3, 2'b00);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_count", 64'(sat_count), 64'd0);
        check("mid_rst_sticky", 64'(sat_sticky), 64'd0);
        check("mid_rst_data", 64'(out_data), 64'd0);
        idle(4);

        check("drain", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
